// File: rtl/spi_master_ctrl.sv
// Command-level SPI master: turns one write/read request into the slave's two
// 10-bit frames (cmd + payload) and deserialises the read byte from MISO.
module spi_master_ctrl #(
  parameter int SS_GAP = 2,
  parameter int RD_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       op_done,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int MAXG = (SS_GAP > RD_GAP) ? SS_GAP : RD_GAP;
  localparam int MAXC = (MAXG > 10) ? MAXG : 10;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, START, SHIFT, RD_WAIT, RECV, GAP, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          frame2_q, frame2_d;
  logic [9:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      wdata_q  <= '0;
      frame2_q <= 1'b0;
      sh_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      ss_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      frame2_q <= frame2_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      ss_n_q   <= ss_n_d;
      mosi_q   <= mosi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    frame2_d = frame2_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          wdata_d  = cmd_wdata;
          frame2_d = 1'b0;
          sh_d     = {(cmd_op ? 2'b00 : 2'b10), cmd_addr};
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d  = {sh_q[8:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(9)) begin
          cnt_d   = '0;
          state_d = (frame2_q && !op_q) ? RD_WAIT : GAP;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RD_GAP - 1)) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        rx_d  = {rx_q[6:0], MISO};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SS_GAP - 1)) begin
          cnt_d = '0;
          if (frame2_q) begin
            // rx_q is complete by now; publish it as DONE starts
            if (!op_q) rdata_d = rx_q;
            state_d = DONE;
          end else begin
            frame2_d = 1'b1;
            sh_d     = {(op_q ? 2'b01 : 2'b11), (op_q ? wdata_q : 8'h00)};
            state_d  = START;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Serial pins are registered from the next state so SS_n cannot glitch
    ss_n_d = !(state_d inside {START, SHIFT, RD_WAIT, RECV});
    mosi_d = (state_d == SHIFT) ? sh_d[9] : 1'b0;
  end

  assign cmd_ready = (state_q == IDLE);
  assign op_done   = (state_q == DONE);
  assign rsp_valid = (state_q == DONE) && !op_q;
  assign rsp_rdata = rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default gaps and SS_GAP=RD_GAP=1),
// each talking to a frame-level behavioural SPI RAM slave.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd_valid;
  logic       cmd_op;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [1:0] rdy, rv, done, ssn, mo;
  logic [7:0] rdata [2];

  int ncmp = 0;
  int nerr = 0;
  int acc  = 0;
  logic [7:0] ref_mem [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : G
    localparam int SSG = (g == 0) ? 2 : 1;
    localparam int RDG = (g == 0) ? 2 : 1;
    logic       ss_n_l, mosi_l, rdy_l, rv_l, done_l;
    logic       miso_l = 1'b0;
    logic [7:0] rd_l;

    spi_master_ctrl #(.SS_GAP(SSG), .RD_GAP(RDG)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(rdy_l),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv_l), .rsp_rdata(rd_l), .op_done(done_l),
      .SS_n(ss_n_l), .MOSI(mosi_l), .MISO(miso_l)
    );

    assign rdy[g]   = rdy_l;
    assign rv[g]    = rv_l;
    assign done[g]  = done_l;
    assign ssn[g]   = ss_n_l;
    assign mo[g]    = mosi_l;
    assign rdata[g] = rd_l;

    // Slave: cycle 0 of a low period is the command-check cycle, 1..10 the
    // frame bits; an 11-frame answers RDG cycles later, MSB first.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [9:0] flog [$];
    int         glog [$];
    int         lowcnt = 0, highcnt = 0, k;
    bit         seen = 0;
    logic [9:0] fr = '0;
    logic [7:0] la = '0, rbyte = '0;

    always @(negedge clk) begin
      if (ss_n_l == 1'b0) begin
        if (lowcnt == 0 && seen) glog.push_back(highcnt);
        highcnt = 0;
        seen    = 1;
        if (lowcnt >= 1 && lowcnt <= 10) fr = {fr[8:0], mosi_l};
        if (lowcnt == 10) begin
          flog.push_back(fr);
          case (fr[9:8])
            2'b00, 2'b10: la = fr[7:0];
            2'b01:        mem[la] = fr[7:0];
            default:      rbyte = mem[la];
          endcase
        end
        k = lowcnt - 11 - RDG;
        miso_l = (fr[9:8] == 2'b11 && lowcnt > 10 && k >= 0 && k <= 7) ? rbyte[7-k] : 1'b0;
        lowcnt++;
      end else begin
        lowcnt = 0;
        miso_l = 1'b0;
        if (seen) highcnt++;
      end
    end
  end

  always @(posedge clk) if (!rst && cmd_valid[0] && rdy[0]) acc++;

  function automatic int nfr(input int inst);
    return (inst == 0) ? G[0].flog.size() : G[1].flog.size();
  endfunction
  function automatic logic [9:0] frm(input int inst, input int i);
    return (inst == 0) ? G[0].flog[i] : G[1].flog[i];
  endfunction
  function automatic int ngap(input int inst);
    return (inst == 0) ? G[0].glog.size() : G[1].glog.size();
  endfunction
  function automatic int gapv(input int inst, input int i);
    return (inst == 0) ? G[0].glog[i] : G[1].glog[i];
  endfunction
  function automatic logic [7:0] smem(input int inst, input logic [7:0] a);
    return (inst == 0) ? G[0].mem[a] : G[1].mem[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int inst, input logic op, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic rvs);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid[inst] = 1'b1;
    while (!rdy[inst] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      ncmp++; nerr++;
      $display("FAIL accept_timeout: got no cmd_ready expected ready within 100 cycles");
    end
    @(negedge clk);
    cmd_valid[inst] = 1'b0;
    lat = 1;
    while (!done[inst] && lat < 200) begin @(negedge clk); lat++; end
    rd  = rdata[inst];
    rvs = rv[inst];
  endtask

  task automatic op_chk(input int inst, input logic op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input string nm);
    int ssg = (inst == 0) ? 2 : 1;
    int rdg = (inst == 0) ? 2 : 1;
    int lat, f0;
    logic [7:0] rd;
    logic rvs;
    f0 = nfr(inst);
    do_op(inst, op, a, d, lat, rd, rvs);
    chk({nm, "_lat"}, lat, op ? 2*(11+ssg)+1 : 2*(11+ssg)+rdg+9);
    chk({nm, "_nframes"}, nfr(inst) - f0, 2);
    if (nfr(inst) - f0 >= 2) begin
      chk({nm, "_frame1"}, frm(inst, f0),     {(op ? 2'b00 : 2'b10), a});
      chk({nm, "_frame2"}, frm(inst, f0 + 1), {(op ? 2'b01 : 2'b11), (op ? d : 8'h00)});
    end
    chk({nm, "_rsp_valid"}, rvs, !op);
    if (!op) chk({nm, "_rdata"}, rd, exp_rd);
    else begin
      chk({nm, "_ram"}, smem(inst, a), d);
      ref_mem[inst][a] = d;
    end
  endtask

  typedef struct {
    logic       op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int a0, f0, g0, n, mingap, dcnt;
    logic op;
    logic [7:0] a, d;

    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'h00};
    tbl[1] = '{1'b0, 8'hA5, 8'h00, 8'h3C};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 8'h00};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 8'hFF};
    tbl[5] = '{1'b0, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 2; i++) for (int j = 0; j < 256; j++) ref_mem[i][j] = 8'h00;

    rst = 1'b1; cmd_valid = 2'b00; cmd_op = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", ssn[0], 1'b1);
    chk("rst_mosi", mo[0], 1'b0);
    chk("rst_op_done", done[0], 1'b0);
    chk("rst_rsp_valid", rv[0], 1'b0);
    chk("rst_rdata", rdata[0], 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy[0], 1'b1);

    for (int i = 0; i < 6; i++)
      op_chk(0, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, $sformatf("tbl%0d", i));

    // Abort a write in the middle of its data frame
    @(negedge clk);
    cmd_op = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h99; cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_in_frame", ssn[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_ss_n", ssn[0], 1'b1);
    chk("abort_mosi", mo[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", rdy[0], 1'b1);
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (done[0]) dcnt++; end
    chk("abort_no_done", dcnt, 0);
    chk("abort_ram", smem(0, 8'h40), ref_mem[0][8'h40]);
    op_chk(0, 1'b0, 8'hA5, 8'h00, 8'h3C, "post_abort_rd");

    // Three back-to-back ops with cmd_valid held high throughout
    a0 = acc; f0 = nfr(0); g0 = ngap(0);
    @(negedge clk);
    cmd_op = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h77; cmd_valid[0] = 1'b1;
    for (int op_i = 0; op_i < 3; op_i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!done[0] && n < 200);
      chk($sformatf("b2b%0d_done", op_i), done[0], 1'b1);
      chk($sformatf("b2b%0d_busy_in_done", op_i), rdy[0], 1'b0);
      if (op_i == 1) begin
        chk("b2b_rsp_valid", rv[0], 1'b1);
        chk("b2b_rdata", rdata[0], 8'h77);
      end
      if (op_i == 0) begin cmd_op = 1'b0; cmd_addr = 8'h10; end
      if (op_i == 1) begin cmd_op = 1'b1; cmd_addr = 8'h11; cmd_wdata = 8'h00; end
      if (op_i == 2) cmd_valid[0] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("b2b_accepts", acc - a0, 3);
    chk("b2b_frames", nfr(0) - f0, 6);
    chk("b2b_gaps", ngap(0) - g0, 6);
    mingap = 1000;
    for (int i = g0; i < ngap(0); i++) if (gapv(0, i) < mingap) mingap = gapv(0, i);
    chk("b2b_min_gap_ge2", mingap >= 2, 1'b1);
    chk("b2b_ram10", smem(0, 8'h10), 8'h77);
    chk("b2b_ram11", smem(0, 8'h11), 8'h00);
    ref_mem[0][8'h10] = 8'h77;
    ref_mem[0][8'h11] = 8'h00;

    // Short-gap instance
    op_chk(1, 1'b1, 8'hA5, 8'h3C, 8'h00, "sweep_wr");
    op_chk(1, 1'b0, 8'hA5, 8'h00, 8'h3C, "sweep_rd");

    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = (i % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      op_chk(0, op, a, d, ref_mem[0][a], $sformatf("rnd0_%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      op_chk(1, op, a, d, ref_mem[1][a], $sformatf("rnd1_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Command-level SPI master that sequences single-byte RAM transactions to the SPI_Wrapper slave (SPI slave + single-port RAM) over SS_n/MOSI/MISO.
Accepts one write or read request at a time over a valid/ready port and breaks it into the slave's 10-bit frames: 00+addr then 01+data for a write, and 10+addr then 11+dummy for a read.
Deserialises the 8-bit read byte from MISO and returns it on a response port.
Sits between the system-side requester and SPI_Wrapper, and replaces the hand-driven bench sequencing.

Parameters:
SS_GAP, 2, cycles SS_n is held high after every frame (min 1)
RD_GAP, 2, idle cycles between the last MOSI bit of an 11-frame and the first MISO sample (min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  request present
cmd_ready  out  1  controller idle, request accepted when cmd_valid&&cmd_ready
cmd_op  in  1  1=write, 0=read
cmd_addr  in  8  RAM address
cmd_wdata  in  8  write byte (ignored for read)
rsp_valid  out  1  one-cycle pulse, rsp_rdata valid (reads only)
rsp_rdata  out  8  read byte, held until next read completes
op_done  out  1  one-cycle pulse when any op finishes (cmd_ready reasserts next cycle)
SS_n  out  1  slave select, active low
MOSI  out  1  serial out, MSB first
MISO  in  1  serial in, MSB first

Behaviour:
- Reset (async, any state): state=IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_rdata=0, op_done=0, counters=0. cmd_ready=1 after release. An in-flight frame is abandoned with no completion pulse.
- cmd_ready=1 only in IDLE. On acceptance, latch op/addr/wdata. Frame 1 starts the next cycle. Inputs are don't-care while busy.
- States: IDLE, START, SHIFT, RD_WAIT, RECV, GAP, DONE.
- START (1 cycle): SS_n=0, MOSI=0. This is the slave's IDLE->CHK_CMD cycle.
- SHIFT (10 cycles): SS_n=0, MOSI=frame[9..0] MSB first, one bit per cycle. Frame = {cmd[1:0], payload[7:0]}.
- Frame 1 = {op?00:10, addr}. Frame 2 = {op?01:11, op?wdata:8'h00}.
- After SHIFT of a 00/01/10 frame: go to GAP.
- After SHIFT of an 11 frame: go to RD_WAIT.
- RD_WAIT (RD_GAP cycles): SS_n=0, MOSI=0.
- RECV (8 cycles): SS_n=0, MOSI=0. Shift MISO into the rx shift register at each rising edge, MSB first.
- GAP (SS_GAP cycles): SS_n=1, MOSI=0. Then START for frame 2, or DONE after frame 2.
- DONE (1 cycle): op_done=1, SS_n=1. Next state IDLE.
- rsp_rdata/rsp_valid: on a read, rsp_rdata is loaded and rsp_valid=1 in the same DONE cycle.
- Busy length, acceptance edge to op_done cycle inclusive:
  - write: 2*(11+SS_GAP)+1 cycles (defaults: 27)
  - read: 2*(11+SS_GAP)+RD_GAP+8+1 cycles (defaults: 37)
- SS_n never glitches low between frames. There are always ≥SS_GAP high cycles between frames and between consecutive ops.
- Back-to-back: cmd_valid held high in DONE is not accepted. Acceptance is earliest in the IDLE cycle following DONE.
- Counters are saturating-free mod counters sized for max(10, 8, SS_GAP, RD_GAP). No wrap occurs inside a frame.

Test Plan:
- Reset: assert rst mid-SHIFT of a write -> SS_n=1, MOSI=0 and cmd_ready=1 immediately after release. No op_done pulse. Slave RAM unchanged at that addr.
- Write addr=8'hA5, wdata=8'h3C -> MOSI streams 00_10100101, then after 2 high cycles 01_00111100. op_done 27 cycles after acceptance. SPI_Wrapper RAM[8'hA5]==8'h3C.
- Read addr=8'hA5 after the above -> frames 10_10100101 and 11_00000000. rsp_valid with rsp_rdata=8'h3C, 37 cycles after acceptance.
- Preload RAM[8'h00]=8'hFF and RAM[8'hFF]=8'h01, read both -> 8'hFF, 8'h01. Checks address/data boundary values and MISO bit ordering.
- cmd_valid held high for 3 back-to-back ops (write 8'h10/8'h77, read 8'h10, write 8'h11/8'h00) -> exactly 3 acceptances. SS_n high ≥2 cycles between every frame. Read returns 8'h77.
- Parameter sweep SS_GAP=1, RD_GAP=1 -> read latency 34 cycles. Data still correct against SPI_Wrapper.
